// File: rtl/aes_decoder.sv
// AES-128 inverse cipher, one round per clock, with an iterative key
// expansion that runs once after every reset and then holds all 11 round keys.

package aes_dec_pkg;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One column of InvMixColumns: circulant matrix 0e 0b 0d 09.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2    = xtime(a[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

endpackage

module sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [2047:0] TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  // Entry x sits at bits [2047-8x -: 8], i.e. base 8*(255-x) = {~x, 3'b000}.
  assign y = TABLE[{~a, 3'b000} +: 8];
endmodule

module inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [2047:0] TABLE = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };
  assign y = TABLE[{~a, 3'b000} +: 8];
endmodule

// Produces one round key per clock; out = {rk0, rk1, ..., rk10}.
module keyexpansion (
  input  logic          start,
  input  logic          clk,
  input  logic          rst,
  input  logic [127:0]  key,
  output logic [1407:0] out,
  output logic          finish
);
  import aes_dec_pkg::*;

  logic         busy;
  logic [3:0]   n_done;
  logic [7:0]   rcon;
  logic [31:0]  rot_word;
  logic [31:0]  sub_word;
  logic [31:0]  w0, w1, w2, w3;

  // The newest round key always sits in the low 128 bits of out.
  assign rot_word = {out[23:0], out[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sub
    sbox u_sbox (.a(rot_word[31-8*i -: 8]), .y(sub_word[31-8*i -: 8]));
  end

  assign w0 = out[127:96] ^ sub_word ^ {rcon, 24'h0};
  assign w1 = out[95:64]  ^ w0;
  assign w2 = out[63:32]  ^ w1;
  assign w3 = out[31:0]   ^ w2;

  // NOTE: the key bus is cleared on reset as well so stale round keys from a
  // previous anahtar can never be observed while the new expansion runs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out    <= '0;
      busy   <= 1'b0;
      finish <= 1'b0;
      n_done <= 4'd0;
      rcon   <= 8'h01;
    end else if (busy) begin
      out    <= {out[1279:0], w0, w1, w2, w3};
      rcon   <= xtime(rcon);
      n_done <= n_done + 4'd1;
      if (n_done == 4'd9) begin
        busy   <= 1'b0;
        finish <= 1'b1;
      end
    end else if (start && !finish) begin
      out    <= {1280'h0, key};
      busy   <= 1'b1;
      n_done <= 4'd0;
      rcon   <= 8'h01;
    end
  end
endmodule

module aes_decoder (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] anahtar,
  input  logic [127:0] sifre,
  input  logic         g_gecerli,
  output logic         hazir,
  output logic [127:0] blok,
  output logic         c_gecerli
);
  import aes_dec_pkg::*;

  typedef enum logic [1:0] {ANAHTAR, HAZIR, TUR, SON} state_t;

  state_t         state, state_nx;
  logic [127:0]   st;
  logic [3:0]     cnt;
  logic           ks_start, ks_finish;
  logic [1407:0]  ks_out;
  logic [127:0]   rk [11];
  logic [127:0]   rk_sel;
  logic [127:0]   sub_bytes, added, mixed;
  logic           accept, last_round;

  keyexpansion u_keyexp (
    .start  (ks_start),
    .clk    (clk),
    .rst    (rst),
    .key    (anahtar),
    .out    (ks_out),
    .finish (ks_finish)
  );

  for (genvar r = 0; r < 11; r++) begin : g_rk
    assign rk[r] = ks_out[1407-128*r -: 128];
  end

  // InvShiftRows is pure wiring: byte (row, col) reads (row, col-row).
  for (genvar n = 0; n < 16; n++) begin : g_bytes
    localparam int ROW = n % 4;
    localparam int SRC = 4 * (((n / 4) - ROW + 4) % 4) + ROW;
    inv_sbox u_inv_sbox (.a(st[127-8*SRC -: 8]), .y(sub_bytes[127-8*n -: 8]));
  end

  always_comb begin
    rk_sel = '0;
    for (int r = 0; r < 11; r++)
      if (cnt == r[3:0]) rk_sel = rk[r];
  end

  assign added = sub_bytes ^ rk_sel;

  for (genvar c = 0; c < 4; c++) begin : g_cols
    assign mixed[127-32*c -: 32] = inv_mix_col(added[127-32*c -: 32]);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ANAHTAR;
    else     state <= state_nx;
  end

  // NOTE: each combinational output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    unique case (state)
      ANAHTAR: if (ks_finish)     state_nx = HAZIR;
      HAZIR:   if (g_gecerli)     state_nx = TUR;
      TUR:     if (cnt == 4'd1)   state_nx = SON;
      SON:                        state_nx = HAZIR;
    endcase
  end

  always_comb begin
    ks_start   = 1'b0;
    hazir      = 1'b0;
    accept     = 1'b0;
    last_round = 1'b0;
    unique case (state)
      ANAHTAR: ks_start = 1'b1;
      HAZIR: begin
        hazir  = 1'b1;
        accept = g_gecerli;
      end
      TUR:     ;
      SON:     last_round = 1'b1;
    endcase
  end

  // Counter reaches 0 on leaving TUR, which selects rk0 for the final round.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st  <= '0;
      cnt <= 4'd0;
    end else if (accept) begin
      st  <= sifre ^ rk[10];
      cnt <= 4'd9;
    end else if (state == TUR) begin
      st  <= mixed;
      cnt <= cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blok      <= '0;
      c_gecerli <= 1'b0;
    end else begin
      c_gecerli <= last_round;
      if (last_round) blok <= added;
    end
  end

endmodule

// File: doc/aes_decoder.md
AES_DECODER -- requirements
Module: aes_decoder

Interface
REQ-001 Parameters: none; AES-128 only.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 anahtar  input  128  cipher key; byte 0 = bits [127:120].
REQ-005 sifre  input  128  ciphertext block; byte 0 = bits [127:120]; state is column-major (byte n → row n%4, column n/4).
REQ-006 g_gecerli  input  1  ciphertext valid; a block is accepted on a posedge where g_gecerli=1 and hazir=1.
REQ-007 hazir  output  1  decoder ready to accept a block.
REQ-008 blok  output  128  recovered plaintext; registered.
REQ-009 c_gecerli  output  1  single-cycle strobe; blok holds a new result.

Function
REQ-010 Sub-blocks: the existing keyexpansion module (start, clk, rst, key, out[1407:0], finish) and 16 combinational inv_sbox byte lookups.
- Round key r = out[1407-128*r -: 128], r = 0..10.
REQ-011 FSM states:
- ANAHTAR: key expansion running.
- HAZIR: idle, ready.
- TUR: rounds 9..1.
- SON: final round.
REQ-012 Reset state is ANAHTAR, with keyexpansion start=1.
- ANAHTAR→HAZIR on the posedge where finish=1.
- The round-key bus is then held constant until the next reset.
REQ-013 anahtar is consumed only during ANAHTAR; a key change requires asserting rst.
REQ-014 In HAZIR with g_gecerli=1 (accept edge E0):
- state register ← sifre XOR rk10.
- round counter ← 9.
- move to TUR.
REQ-015 In TUR, each posedge applies, in order:
- InvShiftRows (row n rotated right by n bytes).
- InvSubBytes.
- AddRoundKey(rk[counter]).
- InvMixColumns (matrix 0e 0b 0d 09, circulant, GF(2^8) with polynomial 0x11b).
- Then counter decrements.
REQ-016 TUR→SON on the posedge that applies round 1 (counter = 1).
REQ-017 In SON, one posedge applies InvShiftRows, InvSubBytes and AddRoundKey(rk0), with no InvMixColumns.
- The result is written to blok.
- c_gecerli=1 for exactly the following cycle.
- FSM returns to HAZIR.
REQ-018 Latency:
- The accept edge is E0; rounds 9..1 occur at E1..E9; the final round occurs at E10.
- c_gecerli and the new blok value are visible in the cycle after E10.
- Throughput is one block per 11 cycles.
REQ-019 hazir=1 only in HAZIR.
- It rises in the same cycle as c_gecerli, so a block presented then is accepted at the next edge (back-to-back operation).
REQ-020 g_gecerli while hazir=0 is ignored: the block is not queued and in-flight state is not disturbed.
REQ-021 sifre is sampled only at the accept edge; later changes do not affect the in-flight block.
REQ-022 blok retains its last value until the next SON edge; c_gecerli is never asserted for more than one consecutive cycle.
REQ-023 All XOR and GF arithmetic is bitwise on 8-bit bytes; there is no width extension.
- The 4-bit round counter never goes below 1 while in TUR.

Reset
REQ-024 While rst=1:
- hazir=0, c_gecerli=0, blok=128'h0.
- State register and counter are cleared.
- FSM is in ANAHTAR.
- Outputs take these values asynchronously.
REQ-025 rst during TUR or SON aborts the block silently:
- No c_gecerli.
- Key expansion restarts on rst release using the current anahtar.
REQ-026 After rst release, hazir stays 0 until keyexpansion finish; g_gecerli in that window is ignored.

Verification
REQ-027 Reset/startup: assert rst mid-cycle → hazir=0, c_gecerli=0, blok=0 immediately (asynchronous); after release, hazir=0 until finish, then 1.
REQ-028 FIPS-197 C.1 vector:
- Stimulus: anahtar=000102030405060708090a0b0c0d0e0f, sifre=69c4e0d86a7b0430d8cdb78070b4c55a.
- Required: blok=00112233445566778899aabbccddeeff with c_gecerli high in the cycle after E10 only.
REQ-029 FIPS-197 Appendix B vector back-to-back:
- Stimulus: anahtar=2b7e151628aed2a6abf7158809cf4f3c; send sifre=3925841d02dc09fbdc118597196a0b32 three times, each presented as soon as hazir rises.
- Required: three results of 3243f6a8885a308d313198a2e0370734, spaced exactly 11 cycles apart.
REQ-030 Busy drop:
- Stimulus: hold g_gecerli=1 with a different sifre during cycles E1..E10.
- Required: the first result is unchanged; the second block is accepted only at the edge after c_gecerli.
REQ-031 Reset mid-operation: assert rst at E5 → no c_gecerli, blok=0; after key expansion completes, the C.1 vector decrypts correctly.
REQ-032 Loopback with aes_engine on 1000 random key/block pairs: the decoder output equals the original plaintext in every case.
